// File: rtl/arb_pkg.sv
// Shared types and constants for the two-requester round-robin arbiter.
// The state encoding doubles as the one-hot {B,A} grant vector.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_A = 2'b01,
        GRANT_B = 2'b10
    } arb_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Any encoding other than a legal grant state reads back as "no grant".
    function automatic logic [1:0] grant_of(input arb_state_t s);
        logic [1:0] g;
        g = 2'b00;
        if (s == GRANT_A) g = 2'b01;
        if (s == GRANT_B) g = 2'b10;
        return g;
    endfunction

endpackage

// File: rtl/mux2.sv
// Catalog two-input mux: C follows A when sel=0, B when sel=1.
module mux2 #(
    parameter int n = 32
) (
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic         sel,
    output logic [n-1:0] C
);

    assign C = sel ? B : A;

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter sharing one valid/ready downstream port between requesters A and B.
// Grant is registered; data passes combinationally through a mux2 steered by the grant.
module mux2_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         a_valid,
    input  logic [N-1:0] a_data,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [N-1:0] b_data,
    output logic         b_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   grant
);

    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    arb_state_t    state_reg, state_next;
    logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
    logic          last_reg, last_next;

    logic       sel;
    logic       x_valid;
    logic       y_valid;
    logic       fire;
    arb_state_t other_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= '0;
            last_reg     <= SEL_B;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            last_reg     <= last_next;
        end
    end

    // x = currently granted requester, y = the other one.
    assign sel         = (state_reg == GRANT_B) ? SEL_B : SEL_A;
    assign x_valid     = sel ? b_valid : a_valid;
    assign y_valid     = sel ? a_valid : b_valid;
    assign fire        = x_valid & out_ready;
    assign other_grant = sel ? GRANT_A : GRANT_B;
    assign grant       = grant_of(state_reg);

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        last_next     = last_reg;
        out_valid     = 1'b0;
        a_ready       = 1'b0;
        b_ready       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (a_valid && b_valid) begin
                    state_next = (last_reg == SEL_B) ? GRANT_A : GRANT_B;
                end else if (a_valid) begin
                    state_next = GRANT_A;
                end else if (b_valid) begin
                    state_next = GRANT_B;
                end
            end

            GRANT_A, GRANT_B: begin
                out_valid = x_valid;
                a_ready   = (state_reg == GRANT_A) & out_ready;
                b_ready   = (state_reg == GRANT_B) & out_ready;

                if (!x_valid) begin
                    state_next    = y_valid ? other_grant : IDLE;
                    hold_cnt_next = '0;
                    last_next     = sel;
                end else if (fire && (hold_cnt_reg == HOLD_LAST) && y_valid) begin
                    state_next    = other_grant;
                    hold_cnt_next = '0;
                    last_next     = sel;
                end else if (fire) begin
                    // Only beats taken while the other side waits count toward the limit.
                    if (!y_valid) begin
                        hold_cnt_next = '0;
                    end else if (hold_cnt_reg != HOLD_LAST) begin
                        hold_cnt_next = hold_cnt_reg + HW'(1);
                    end
                end
            end

            default: begin
                state_next    = IDLE;
                hold_cnt_next = '0;
            end
        endcase
    end

    mux2 #(.n(N)) u_mux2 (
        .A   (a_data),
        .B   (b_data),
        .sel (sel),
        .C   (out_data)
    );

endmodule

// File: tb/tb_mux2_arbiter.sv
// Randomised and directed bench for mux2_arbiter, checked against an ownership-level
// model: who owns the port, how many beats it took while the other waited, who went last.
module tb_mux2_arbiter;

    localparam int N        = 32;
    localparam int MAX_HOLD = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         a_valid, b_valid, out_ready;
    logic [N-1:0] a_data, b_data;
    logic         a_ready, b_ready, out_valid;
    logic [N-1:0] out_data;
    logic [1:0]   grant;

    always #5 clk = ~clk;

    mux2_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .grant     (grant)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    // Reference model: owner 0 = nobody, 1 = A, 2 = B.
    int m_owner, m_streak, m_last;
    int na, nb;
    bit fixed_data;
    bit last_fa, last_fb;
    logic [1:0]   obs_grant;
    logic         obs_ov, obs_ar, obs_br;
    logic [N-1:0] obs_data;
    int           log_owner[$];
    logic [N-1:0] log_data[$];

    task automatic model_reset();
        m_owner  = 0;
        m_streak = 0;
        m_last   = 2;
    endtask

    // Called at a falling edge with inputs already chosen; checks outputs, then advances the model.
    task automatic cycle();
        logic [1:0]   eg;
        logic         ev, ear, ebr;
        logic [N-1:0] ed;
        bit           xv, yv;
        #1;
        eg = 2'b00; ev = 1'b0; ear = 1'b0; ebr = 1'b0; ed = a_data;
        if (m_owner == 1) begin
            eg = 2'b01; ev = a_valid; ear = out_ready;
        end else if (m_owner == 2) begin
            eg = 2'b10; ev = b_valid; ebr = out_ready; ed = b_data;
        end
        obs_grant = grant; obs_ov = out_valid; obs_ar = a_ready; obs_br = b_ready; obs_data = out_data;
        chk("grant", {30'd0, grant}, {30'd0, eg});
        chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
        chk("a_ready", {31'd0, a_ready}, {31'd0, ear});
        chk("b_ready", {31'd0, b_ready}, {31'd0, ebr});
        if (ev) chk("out_data", out_data, ed);

        last_fa = a_valid && ear;
        last_fb = b_valid && ebr;
        if (last_fa || last_fb) begin
            log_owner.push_back(last_fa ? 1 : 2);
            log_data.push_back(ed);
            $display("t=%0t beat %s data %h", $time, last_fa ? "A" : "B", ed);
        end

        if (m_owner == 0) begin
            if (a_valid && b_valid) m_owner = (m_last == 2) ? 1 : 2;
            else if (a_valid)       m_owner = 1;
            else if (b_valid)       m_owner = 2;
        end else begin
            xv = (m_owner == 1) ? a_valid : b_valid;
            yv = (m_owner == 1) ? b_valid : a_valid;
            if (!xv) begin
                m_last   = m_owner;
                m_owner  = yv ? 3 - m_owner : 0;
                m_streak = 0;
            end else if (out_ready) begin
                if (yv) begin
                    m_streak++;
                    if (m_streak == MAX_HOLD) begin
                        m_last   = m_owner;
                        m_owner  = 3 - m_owner;
                        m_streak = 0;
                    end
                end else begin
                    m_streak = 0;
                end
            end
        end

        if (!fixed_data && last_fa) a_data = 32'hAAAA_0000 + 32'(++na);
        if (!fixed_data && last_fb) b_data = 32'h5555_0000 + 32'(++nb);
        @(negedge clk);
    endtask

    initial begin
        na = 0; nb = 0; fixed_data = 0;
        rst_n = 1'b0; out_ready = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1;
        a_data = 32'hAAAA_0000; b_data = 32'h5555_0000;
        model_reset();

        // Reset holds everything quiet even with both requesting.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
        chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
        chk("rst_out_data", out_data, a_data);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("rst_release_idle", {30'd0, obs_grant}, 32'd0);

        // Fairness: AAAA BBBB AAAA with A first.
        log_owner.delete(); log_data.delete();
        repeat (12) cycle();
        chk("fair_beats", log_owner.size(), 32'd12);
        for (int i = 0; i < 12 && i < log_owner.size(); i++)
            chk($sformatf("fair_owner%0d", i), log_owner[i], (i >= 4 && i < 8) ? 32'd2 : 32'd1);

        // Backpressure under GRANT_B.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_grant", {30'd0, obs_grant}, 32'd2);
            chk("bp_out_valid", {31'd0, obs_ov}, 32'd1);
            chk("bp_b_ready", {31'd0, obs_br}, 32'd0);
            chk("bp_data", obs_data, 32'h5555_0000 + 32'(nb));
        end
        out_ready = 1'b1;
        log_owner.delete(); log_data.delete();
        repeat (8) cycle();
        for (int i = 0; i < 8 && i < log_owner.size(); i++)
            chk($sformatf("bp_owner%0d", i), log_owner[i], (i < 4) ? 32'd2 : 32'd1);

        // Solo A with constant data.
        b_valid = 1'b0;
        repeat (2) cycle();
        fixed_data = 1; a_data = 32'hAAAA_0001;
        log_owner.delete(); log_data.delete();
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("solo_grant", {30'd0, obs_grant}, 32'd1);
        end
        chk("solo_beats", log_owner.size(), 32'd6);
        for (int i = 0; i < log_data.size(); i++)
            chk("solo_data", log_data[i], 32'hAAAA_0001);

        // A drops while B waits: one bubble, then B.
        a_valid = 1'b0; b_valid = 1'b1; b_data = 32'h5555_0002;
        cycle();
        chk("bubble_out_valid", {31'd0, obs_ov}, 32'd0);
        out_ready = 1'b0;
        cycle();
        chk("bubble_grant", {30'd0, obs_grant}, 32'd2);
        chk("bubble_data", obs_data, 32'h5555_0002);

        // Reset between edges while B holds the port.
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_grant", {30'd0, grant}, 32'd0);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_b_ready", {31'd0, b_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; model_reset();
        a_valid = 1'b1; out_ready = 1'b1; fixed_data = 0;
        cycle();
        cycle();
        chk("midrst_tie_a", {30'd0, obs_grant}, 32'd1);

        // Random traffic: requesters hold valid/data until accepted.
        for (int i = 0; i < 600; i++) begin
            if (!a_valid || last_fa) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_data  = $urandom;
            end
            if (!b_valid || last_fb) begin
                b_valid = ($urandom_range(0, 3) != 0);
                b_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 9) < 7);
            fixed_data = 1;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
